// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command sequencer for the 8-bit bitslice ALU; ALU_SEQ_MUL_EN enables shift-add multiply
module alu_op_sequencer #(
  parameter int          WIDTH  = 8,
  parameter logic [3:0]  MUL_OP = 4'b1111
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_x,
  input  logic [WIDTH-1:0]     cmd_y,
  input  logic                 cmd_shin,
  output logic [3:0]           alu_op_code,
  output logic [WIDTH-1:0]     alu_x,
  output logic [WIDTH-1:0]     alu_y,
  output logic                 alu_cin,
  output logic                 alu_cin2c,
  output logic                 alu_lsb_y,
  output logic                 alu_left_i,
  output logic                 alu_right_i,
  input  logic [WIDTH-1:0]     alu_z,
  input  logic                 alu_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_cout,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
`ifdef ALU_SEQ_MUL_EN
    , S_MUL
`endif
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       op_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic             shin_r;
  logic             op_illegal;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] p_hi;
  logic [2:0]       count;
  logic             mul_c;
  logic [WIDTH-1:0] mul_s;

  // One shift-add step: keep the ALU sum only when the multiplier LSB is set.
  always_comb begin
    mul_c = y_r[0] & alu_cout;
    mul_s = y_r[0] ? alu_z : p_hi;
  end

  assign op_illegal = 1'b0;
`else
  assign op_illegal = (op_r == MUL_OP);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_op_code = 4'b0000;
    alu_x       = '0;
    alu_y       = '0;
    alu_cin     = 1'b0;
    alu_cin2c   = 1'b0;
    alu_lsb_y   = 1'b0;
    alu_left_i  = 1'b0;
    alu_right_i = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
`ifdef ALU_SEQ_MUL_EN
          if (cmd_op == MUL_OP) state_nxt = S_MUL;
          else                  state_nxt = S_EXEC;
`else
          state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        // An illegal opcode keeps the ALU lines quiet.
        if (!op_illegal) begin
          alu_op_code = op_r;
          alu_x       = x_r;
          alu_y       = y_r;
          alu_cin2c   = (op_r == 4'b0001);
          alu_left_i  = shin_r;
          alu_right_i = shin_r;
        end
        state_nxt = S_DONE;
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        alu_op_code = 4'b0000;
        alu_x       = p_hi;
        alu_y       = x_r;
        alu_lsb_y   = y_r[0];
        if (count == 3'd7) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r       <= 4'b0000;
      x_r        <= '0;
      y_r        <= '0;
      shin_r     <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      p_hi       <= '0;
      count      <= 3'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r   <= cmd_op;
            x_r    <= cmd_x;
            y_r    <= cmd_y;
            shin_r <= cmd_shin;
`ifdef ALU_SEQ_MUL_EN
            p_hi   <= '0;
            count  <= 3'd0;
`endif
          end
        end
        S_EXEC: begin
          rsp_result <= op_illegal ? '0 : {{WIDTH{1'b0}}, alu_z};
          rsp_cout   <= op_illegal ? 1'b0 : alu_cout;
          rsp_err    <= op_illegal;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          // {P_hi,Y} <= low 16 bits of {c,s,Y} >> 1
          p_hi  <= {mul_c, mul_s[WIDTH-1:1]};
          y_r   <= {mul_s[0], y_r[WIDTH-1:1]};
          count <= count + 3'd1;
          if (count == 3'd7) begin
            rsp_result <= {mul_c, mul_s, y_r[WIDTH-1:1]};
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

  localparam logic [3:0] MUL_OP = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        cmd_shin;
  logic [3:0]  alu_op_code;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic        alu_cin;
  logic        alu_cin2c;
  logic        alu_lsb_y;
  logic        alu_left_i;
  logic        alu_right_i;
  logic [7:0]  alu_z;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_shin(cmd_shin),
    .alu_op_code(alu_op_code), .alu_x(alu_x), .alu_y(alu_y),
    .alu_cin(alu_cin), .alu_cin2c(alu_cin2c), .alu_lsb_y(alu_lsb_y),
    .alu_left_i(alu_left_i), .alu_right_i(alu_right_i),
    .alu_z(alu_z), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the bitslice ALU: returns {cout, z}.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                                        input logic cin, input logic cin2c, input logic li, input logic ri);
    logic [8:0] r;
    case (op)
      4'h0:    r = {1'b0, x} + {1'b0, y} + {8'b0, cin};
      4'h1:    r = {1'b0, x} + {1'b0, ~y} + {8'b0, cin2c};
      4'h2:    r = {1'b0, x & y};
      4'h3:    r = {1'b0, x | y};
      4'h4:    r = {1'b0, x ^ y};
      4'h5:    r = {x[7], x[6:0], ri};
      4'h6:    r = {x[0], li, x[7:1]};
      default: r = {1'b0, x};
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_z} = alu_fn(alu_op_code, alu_x, alu_y, alu_cin, alu_cin2c, alu_left_i, alu_right_i);

  // Expected response {err, cout, result} for a command.
  function automatic logic [17:0] model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, input logic shin);
    logic [8:0]  a;
    logic [15:0] p;
    if (op == MUL_OP) begin
`ifdef ALU_SEQ_MUL_EN
      p = x * y;
      return {2'b00, p};
`else
      return {1'b1, 1'b0, 16'h0000};
`endif
    end
    a = alu_fn(op, x, y, 1'b0, (op == 4'h1), shin, shin);
    return {1'b0, a[8], 8'h00, a[7:0]};
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
    if (op == MUL_OP) return 9;
`endif
    return 2;
  endfunction

  function automatic logic [22:0] alu_bus();
    return {alu_op_code, alu_x, alu_y, alu_cin, alu_cin2c, alu_lsb_y, alu_left_i, alu_right_i};
  endfunction

  // Issues one command from IDLE and waits (bounded) for the response; leaves it un-acknowledged.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, input logic shin,
                         output int lat, output logic [15:0] res, output logic cout, output logic err,
                         output logic [3:0] op_seen, output logic cin2c_seen, output logic ready_seen);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_shin = shin; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    lat        = 1;
    op_seen    = alu_op_code;
    cin2c_seen = alu_cin2c;
    ready_seen = cmd_ready;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = rsp_result; cout = rsp_cout; err = rsp_err;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 4'h0; cmd_x = 8'h00; cmd_y = 8'h00; cmd_shin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_cout, rsp_err} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags got %b want 1000", {cmd_ready, rsp_valid, rsp_cout, rsp_err});
    end
    n_checks++;
    if (rsp_result !== 16'h0000) begin
      n_fail++; $display("FAIL reset_result got %h want 0000", rsp_result);
    end
    n_checks++;
    if (alu_bus() !== 23'h0) begin
      n_fail++; $display("FAIL reset_alu got %h want 0", alu_bus());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat; logic [15:0] res; logic cout, err, c2c, rdy; logic [3:0] ops;
    for (int i = 0; i < 2; i++) begin
      run_cmd(4'h0, (i == 0) ? 8'h7F : 8'hFF, 8'h01, 1'b0, lat, res, cout, err, ops, c2c, rdy);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL add_latency[%0d] got %0d want 2", i, lat); end
      n_checks++;
      if (res !== ((i == 0) ? 16'h0080 : 16'h0000)) begin
        n_fail++; $display("FAIL add_result[%0d] got %h want %h", i, res, (i == 0) ? 16'h0080 : 16'h0000);
      end
      n_checks++;
      if ({cout, err} !== {i[0], 1'b0}) begin
        n_fail++; $display("FAIL add_cout_err[%0d] got %b want %b", i, {cout, err}, {i[0], 1'b0});
      end
      n_checks++;
      if (rdy !== 1'b0) begin n_fail++; $display("FAIL add_cmd_ready_exec got %b want 0", rdy); end
      ack_rsp();
    end
  endtask

  task automatic test_sub();
    int lat; logic [15:0] res; logic cout, err, c2c, rdy; logic [3:0] ops;
    run_cmd(4'h1, 8'h05, 8'h07, 1'b0, lat, res, cout, err, ops, c2c, rdy);
    n_checks++;
    if ({ops, c2c} !== 5'b0001_1) begin n_fail++; $display("FAIL sub_exec_lines got %b want 00011", {ops, c2c}); end
    n_checks++;
    if (res !== 16'h00FE) begin n_fail++; $display("FAIL sub_result got %h want 00fe", res); end
    ack_rsp();
  endtask

  task automatic test_mul_op();
    int lat; logic [15:0] res; logic cout, err, c2c, rdy; logic [3:0] ops;
    logic [7:0] x, y; logic [17:0] e;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: begin x = 8'h0D; y = 8'h0B; end
        1: begin x = 8'hFF; y = 8'hFF; end
        2: begin x = 8'h00; y = 8'hA5; end
        3: begin x = 8'h03; y = 8'h04; end
        default: begin x = 8'($urandom); y = 8'($urandom); end
      endcase
      e = model(MUL_OP, x, y, 1'b0);
      run_cmd(MUL_OP, x, y, 1'b0, lat, res, cout, err, ops, c2c, rdy);
      n_checks++;
      if (lat !== exp_lat(MUL_OP)) begin n_fail++; $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, exp_lat(MUL_OP)); end
      n_checks++;
      if ({err, cout, res} !== e) begin
        n_fail++; $display("FAIL mul_response[%0d] %h*%h got err=%b cout=%b res=%h want err=%b cout=%b res=%h",
                           i, x, y, err, cout, res, e[17], e[16], e[15:0]);
      end
`ifndef ALU_SEQ_MUL_EN
      n_checks++;
      if ({ops, c2c} !== 5'b0) begin n_fail++; $display("FAIL illegal_alu_quiet got %b want 00000", {ops, c2c}); end
`endif
      ack_rsp();
    end
  endtask

  task automatic test_random_ops();
    int lat; logic [15:0] res; logic cout, err, c2c, rdy; logic [3:0] ops;
    logic [3:0] op; logic [7:0] x, y; logic sh; logic [17:0] e;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14)); x = 8'($urandom); y = 8'($urandom); sh = 1'($urandom);
      e = model(op, x, y, sh);
      run_cmd(op, x, y, sh, lat, res, cout, err, ops, c2c, rdy);
      n_checks++;
      if (lat !== 2 || {err, cout, res} !== e) begin
        n_fail++; $display("FAIL rand_op[%0d] op=%h x=%h y=%h sh=%b got lat=%0d err=%b cout=%b res=%h want lat=2 err=%b cout=%b res=%h",
                           i, op, x, y, sh, lat, err, cout, res, e[17], e[16], e[15:0]);
      end
      ack_rsp();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] res; logic cout, err, c2c, rdy; logic [3:0] ops;
    logic [17:0] e;
    e = model(4'h0, 8'h3C, 8'h5A, 1'b0);
    run_cmd(4'h0, 8'h3C, 8'h5A, 1'b0, lat, res, cout, err, ops, c2c, rdy);
    cmd_op = 4'h1; cmd_x = 8'h11; cmd_y = 8'h22; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({rsp_valid, cmd_ready, rsp_err, rsp_cout, rsp_result} !== {2'b10, e}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b rdy=%b res=%h want v=1 rdy=0 res=%h", i, rsp_valid, cmd_ready, rsp_result, e[15:0]);
      end
    end
    cmd_valid = 1'b0;
    ack_rsp();
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", cmd_ready, rsp_valid);
    end
    e = model(4'h4, 8'hA5, 8'h0F, 1'b0);
    run_cmd(4'h4, 8'hA5, 8'h0F, 1'b0, lat, res, cout, err, ops, c2c, rdy);
    n_checks++;
    if (lat !== 2 || {err, cout, res} !== e) begin
      n_fail++; $display("FAIL bp_next_cmd got lat=%0d res=%h want lat=2 res=%h", lat, res, e[15:0]);
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back(input logic [3:0] op);
    int hs[4]; int w;
    cmd_op = op; cmd_x = 8'h21; cmd_y = 8'h13; cmd_shin = 1'b0;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int h = 0; h < 4; h++) begin
      w = 0;
      while (cmd_ready !== 1'b1 && w < 30) begin @(posedge clk); #1; w++; end
      hs[h] = cyc;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    for (int h = 1; h < 4; h++) begin
      n_checks++;
      if (hs[h] - hs[h-1] !== exp_lat(op) + 1) begin
        n_fail++; $display("FAIL b2b_gap op=%h [%0d] got %0d want %0d", op, h, hs[h] - hs[h-1], exp_lat(op) + 1);
      end
    end
    repeat (12) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int wait_cycles;
`ifdef ALU_SEQ_MUL_EN
    cmd_op = MUL_OP; wait_cycles = 4;
`else
    cmd_op = 4'h0; wait_cycles = 0;
`endif
    cmd_x = 8'hC3; cmd_y = 8'h7E; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (wait_cycles) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, alu_bus()} !== {2'b10, 23'h0}) begin
      n_fail++; $display("FAIL reset_mid_state got rdy=%b v=%b alu=%h want rdy=1 v=0 alu=0", cmd_ready, rsp_valid, alu_bus());
    end
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_rsp got %0d responses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_op();
    test_random_ops();
    test_backpressure();
    test_back_to_back(4'h0);
`ifdef ALU_SEQ_MUL_EN
    test_back_to_back(MUL_OP);
`endif
    test_reset_mid();
    test_random_ops();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
